// File: rtl/cpu_wb_pkg.sv
// Shared encodings and bundle type for the MIPS write-back stage.
package cpu_wb_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 5;

    // Destination register select.
    typedef enum logic [1:0] {
        DST_RT   = 2'b00,
        DST_RD   = 2'b01,
        DST_LINK = 2'b10,
        DST_NONE = 2'b11
    } reg_dst_e;

    // Write-back data source select.
    typedef enum logic [1:0] {
        SRC_ALU  = 2'b00,
        SRC_LOAD = 2'b01,
        SRC_LINK = 2'b10,
        SRC_LESS = 2'b11
    } mem_to_reg_e;

    // Load width / extension mode; unlisted codes behave as word.
    typedef enum logic [2:0] {
        LM_WORD   = 3'b000,
        LM_BYTE_S = 3'b001,
        LM_BYTE_U = 3'b010,
        LM_HALF_S = 3'b011,
        LM_HALF_U = 3'b100
    } load_mode_e;

    // Resolved write-back bundle at the default core widths.
    typedef struct packed {
        logic                 valid;
        logic                 we;
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_bundle_t;

    localparam wb_bundle_t WB_BUBBLE = '{valid: 1'b0, we: 1'b0, addr: '0, data: '0};

endpackage

// File: rtl/load_extend.sv
// Combinational sub-word load lane select and sign/zero extension.
module load_extend
    import cpu_wb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]            read_data,
    input  logic [$clog2(DATA_W/8)-1:0]  byte_off,
    input  logic [2:0]                   load_mode,
    output logic [DATA_W-1:0]            ext_data
);

    localparam int OFF_W = $clog2(DATA_W/8);

    logic [OFF_W-1:0]  half_off_s;
    logic [OFF_W-1:0]  word_off_s;
    logic [DATA_W-1:0] byte_sh_s;
    logic [DATA_W-1:0] half_sh_s;
    logic [DATA_W-1:0] word_sh_s;
    logic [7:0]        byte_s;
    logic [15:0]       half_s;
    logic [31:0]       word_s;
    logic [DATA_W-1:0] word_ext_s;

    // Shift the addressed lane down to bit 0; halfword ignores offset bit 0, word ignores bits 1:0.
    always_comb begin
        half_off_s = byte_off & ~OFF_W'(1);
        word_off_s = byte_off & ~OFF_W'(3);
        byte_sh_s  = read_data >> {byte_off,   3'b000};
        half_sh_s  = read_data >> {half_off_s, 3'b000};
        word_sh_s  = read_data >> {word_off_s, 3'b000};
        byte_s     = byte_sh_s[7:0];
        half_s     = half_sh_s[15:0];
        word_s     = word_sh_s[31:0];
    end

    // On wide datapaths a word load is sign-extended to the full width.
    generate
        if (DATA_W > 32) begin : g_wide
            assign word_ext_s = {{(DATA_W-32){word_s[31]}}, word_s};
        end else begin : g_narrow
            assign word_ext_s = word_s;
        end
    endgenerate

    // Apply the requested extension to the selected lane.
    always_comb begin
        ext_data = word_ext_s;
        case (load_mode_e'(load_mode))
            LM_BYTE_S: ext_data = {{(DATA_W-8){byte_s[7]}}, byte_s};
            LM_BYTE_U: ext_data = {{(DATA_W-8){1'b0}}, byte_s};
            LM_HALF_S: ext_data = {{(DATA_W-16){half_s[15]}}, half_s};
            LM_HALF_U: ext_data = {{(DATA_W-16){1'b0}}, half_s};
            LM_WORD:   ext_data = word_ext_s;
            default:   ext_data = word_ext_s;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Registered write-back stage: destination/source select, load extension,
// stall/flush pipeline register and forwarding-hit compare.
module wb_stage
    import cpu_wb_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int LINK_REG = 31
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         stall,
    input  logic                         flush,
    input  logic                         in_valid,
    input  logic                         in_reg_write,
    input  logic [1:0]                   in_reg_dst,
    input  logic [ADDR_W-1:0]            in_rt,
    input  logic [ADDR_W-1:0]            in_rd,
    input  logic [1:0]                   in_mem_to_reg,
    input  logic [2:0]                   in_load_mode,
    input  logic [$clog2(DATA_W/8)-1:0]  in_byte_off,
    input  logic [DATA_W-1:0]            in_result,
    input  logic [DATA_W-1:0]            in_read_data,
    input  logic [DATA_W-1:0]            in_pc_link,
    input  logic                         in_less,
    input  logic [ADDR_W-1:0]            fwd_addr_a,
    input  logic [ADDR_W-1:0]            fwd_addr_b,
    output logic                         wb_valid,
    output logic                         wb_we,
    output logic [ADDR_W-1:0]            wb_addr,
    output logic [DATA_W-1:0]            wb_data,
    output logic                         fwd_hit_a,
    output logic                         fwd_hit_b
);

    // Bundle sized to this instance's widths.
    typedef struct packed {
        logic              valid;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } stage_bundle_t;

    localparam stage_bundle_t BUBBLE = '0;

    logic [DATA_W-1:0] load_ext_s;
    logic [ADDR_W-1:0] addr_sel_s;
    logic              dst_none_s;
    logic [DATA_W-1:0] data_sel_s;
    stage_bundle_t     next_s;
    stage_bundle_t     wb_r;

    load_extend #(
        .DATA_W (DATA_W)
    ) u_load_extend (
        .read_data (in_read_data),
        .byte_off  (in_byte_off),
        .load_mode (in_load_mode),
        .ext_data  (load_ext_s)
    );

    // Destination select; "no destination" keeps address 0 and forces the write off.
    always_comb begin
        addr_sel_s = '0;
        dst_none_s = 1'b0;
        case (reg_dst_e'(in_reg_dst))
            DST_RT:   addr_sel_s = in_rt;
            DST_RD:   addr_sel_s = in_rd;
            DST_LINK: addr_sel_s = ADDR_W'(LINK_REG);
            DST_NONE: dst_none_s = 1'b1;
            default:  dst_none_s = 1'b1;
        endcase
    end

    // Write-back source select.
    always_comb begin
        data_sel_s = in_result;
        case (mem_to_reg_e'(in_mem_to_reg))
            SRC_ALU:  data_sel_s = in_result;
            SRC_LOAD: data_sel_s = load_ext_s;
            SRC_LINK: data_sel_s = in_pc_link;
            SRC_LESS: data_sel_s = {{(DATA_W-1){1'b0}}, in_less};
            default:  data_sel_s = in_result;
        endcase
    end

    // Assemble the resolved bundle; writes to $0 are dropped but the address is kept.
    always_comb begin
        next_s       = BUBBLE;
        next_s.valid = in_valid;
        next_s.we    = in_valid && in_reg_write && !dst_none_s && (addr_sel_s != '0);
        next_s.addr  = addr_sel_s;
        next_s.data  = data_sel_s;
    end

    // Pipeline register: reset, then flush (beats stall), then stall hold, else load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_r <= BUBBLE;
        end else if (flush) begin
            wb_r <= BUBBLE;
        end else if (stall) begin
            wb_r <= wb_r;
        end else begin
            wb_r <= next_s;
        end
    end

    assign wb_valid = wb_r.valid;
    assign wb_we    = wb_r.we;
    assign wb_addr  = wb_r.addr;
    assign wb_data  = wb_r.data;

    // Same-cycle forwarding compare against the registered write; $0 never hits.
    assign fwd_hit_a = wb_r.we && (wb_r.addr == fwd_addr_a) && (fwd_addr_a != '0);
    assign fwd_hit_b = wb_r.we && (wb_r.addr == fwd_addr_b) && (fwd_addr_b != '0);

endmodule
